// File: rtl/lcd_pkg.sv
// Shared constants and state encodings for the LCD phrase writer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lcd_pkg;

    // HD44780 command bytes used during init and line addressing
    localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display (slow command)
    localparam logic [7:0] LCD_LINE0    = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] LCD_LINE1    = 8'hC0;  // DDRAM address 0x40

    localparam int LCD_COLS = 16;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_INIT,
        ST_INIT_WT,
        ST_IDLE,
        ST_LADDR,
        ST_LADDR_WT,
        ST_FETCH,
        ST_LATCH,
        ST_CHAR_WT
    } lcd_state_t;

    typedef enum logic [1:0] {
        SB_IDLE,
        SB_SETUP,
        SB_EHIGH,
        SB_WAIT
    } strobe_state_t;

    // Init command sequence, in issue order
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_ENTRY;
            default: return LCD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_byte_strobe.sv
// Purpose: drives one byte onto the LCD bus as SETUP (1 cycle) / EHIGH (E_PULSE) / WAIT (CMD_WAIT or CLEAR_WAIT).
// Latency: i_go -> lcdE rise 2 cycles; busy for 1 + E_PULSE + wait cycles.
// Backpressure: o_ready is high when idle and in the last WAIT cycle; i_go is honoured only while idle.
// Ports: clock/reset (async active-high); i_go/i_rs/i_byte/i_long_wait request a byte;
//        o_lcd_rs/o_lcd_e/o_lcd_data drive the LCD pins; o_ready tells the sequencer it may issue the next byte.
module lcd_byte_strobe #(
    parameter int E_PULSE    = 25,
    parameter int CMD_WAIT   = 2000,
    parameter int CLEAR_WAIT = 82000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_go,
    input  logic       i_rs,
    input  logic [7:0] i_byte,
    input  logic       i_long_wait,
    output logic       o_lcd_rs,
    output logic       o_lcd_e,
    output logic [7:0] o_lcd_data,
    output logic       o_ready
);
    import lcd_pkg::*;

    localparam int MAX_A = (E_PULSE > CMD_WAIT) ? E_PULSE : CMD_WAIT;
    localparam int MAX_W = (MAX_A > CLEAR_WAIT) ? MAX_A : CLEAR_WAIT;
    localparam int CW    = $clog2(MAX_W) + 1;

    localparam logic [CW-1:0] E_LAST     = CW'(E_PULSE - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT - 1);

    strobe_state_t r_st;
    logic [CW-1:0] r_cnt;
    logic          r_long;
    logic          r_rs;
    logic          r_e;
    logic [7:0]    r_data;
    logic [CW-1:0] w_wait_last;

    assign w_wait_last = r_long ? CLEAR_LAST : CMD_LAST;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_st   <= SB_IDLE;
            r_cnt  <= '0;
            r_long <= 1'b0;
            r_rs   <= 1'b0;
            r_e    <= 1'b0;
            r_data <= 8'h00;
        end else begin
            case (r_st)
                SB_IDLE: begin
                    // Data and RS are captured here and then held untouched
                    // until the next go, covering SETUP through end of WAIT.
                    if (i_go) begin
                        r_data <= i_byte;
                        r_rs   <= i_rs;
                        r_long <= i_long_wait;
                        r_st   <= SB_SETUP;
                    end
                end
                SB_SETUP: begin
                    r_e   <= 1'b1;
                    r_cnt <= '0;
                    r_st  <= SB_EHIGH;
                end
                SB_EHIGH: begin
                    if (r_cnt == E_LAST) begin
                        r_e   <= 1'b0;
                        r_cnt <= '0;
                        r_st  <= SB_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SB_WAIT: begin
                    if (r_cnt == w_wait_last) begin
                        r_cnt <= '0;
                        r_st  <= SB_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_st <= SB_IDLE;
            endcase
        end
    end

    // Ready is raised in the final WAIT cycle so the next byte's first cycle
    // lands directly after the wait with no dead cycle.
    assign o_ready    = (r_st == SB_IDLE) || ((r_st == SB_WAIT) && (r_cnt == w_wait_last));
    assign o_lcd_rs   = r_rs;
    assign o_lcd_e    = r_e;
    assign o_lcd_data = r_data;

endmodule

// File: rtl/lcd_phrase_writer.sv
// Purpose: initialises a 16x2 HD44780 LCD (8-bit) then writes phrase ROM entries 0..15 / 16..31 to lines 1 / 2.
// Latency: FETCH -> lcdE rise 3 cycles; one character = 3 + E_PULSE + CMD_WAIT cycles.
// Backpressure: start is accepted only in IDLE (busy = 0); otherwise it is dropped, not queued.
// Ports: clock, reset (async active-high), start; romAddr/romData to the 1-cycle phrase ROM;
//        lcdRs/lcdRw/lcdE/lcdData to the LCD pins; busy, done (1-cycle pulse at end of pass).
// Build option: define LCD_AUTO_REFRESH_EN to rewrite the display REFRESH_GAP idle cycles after each pass.
module lcd_phrase_writer #(
    parameter int POWERUP_WAIT = 750000,
    parameter int E_PULSE      = 25,
    parameter int CMD_WAIT     = 2000,
    parameter int CLEAR_WAIT   = 82000,
    parameter int REFRESH_GAP  = 2500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic [4:0] romAddr,
    input  logic [7:0] romData,
    output logic       lcdRs,
    output logic       lcdRw,
    output logic       lcdE,
    output logic [7:0] lcdData,
    output logic       busy,
    output logic       done
);
    import lcd_pkg::*;

    // One counter serves the power-up wait and the refresh gap, so it is
    // sized for whichever is larger.
    localparam int TOP_MAX = (POWERUP_WAIT > REFRESH_GAP) ? POWERUP_WAIT : REFRESH_GAP;
    localparam int CW      = $clog2(TOP_MAX) + 1;

    localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_WAIT - 1);
`ifdef LCD_AUTO_REFRESH_EN
    localparam logic [CW-1:0] GAP_LAST = CW'(REFRESH_GAP - 1);
`endif

    lcd_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_init_idx;
    logic          r_line;
    logic [3:0]    r_col;
    logic [4:0]    r_rom_addr;
    logic          r_busy;
    logic          r_done;
`ifdef LCD_AUTO_REFRESH_EN
    logic          r_armed;
`endif

    logic       w_go;
    logic       w_rs;
    logic [7:0] w_byte;
    logic       w_long;
    logic       w_ready;
    logic       w_kick;

`ifdef LCD_AUTO_REFRESH_EN
    assign w_kick = start || (r_armed && (r_cnt == GAP_LAST));
`else
    assign w_kick = start;
`endif

    // Byte requests are decoded from single-cycle issue states; the strobe
    // is guaranteed idle whenever one of these states is entered.
    always_comb begin
        w_go   = 1'b0;
        w_rs   = 1'b0;
        w_byte = 8'h00;
        case (r_state)
            ST_INIT: begin
                w_go   = 1'b1;
                w_byte = init_cmd(r_init_idx);
            end
            ST_LADDR: begin
                w_go   = 1'b1;
                w_byte = r_line ? LCD_LINE1 : LCD_LINE0;
            end
            ST_LATCH: begin
                w_go   = 1'b1;
                w_rs   = 1'b1;
                w_byte = romData;
            end
            default: ;
        endcase
    end

    // Only the clear command needs the long wait; a character code of 0x01 does not.
    assign w_long = !w_rs && (w_byte == LCD_CLEAR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_PWRUP;
            r_cnt      <= '0;
            r_init_idx <= 2'd0;
            r_line     <= 1'b0;
            r_col      <= 4'd0;
            r_rom_addr <= 5'd0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
`ifdef LCD_AUTO_REFRESH_EN
            r_armed    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_PWRUP: begin
                    if (r_cnt == PWR_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_INIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_INIT: r_state <= ST_INIT_WT;
                ST_INIT_WT: begin
                    if (w_ready) begin
                        if (r_init_idx == 2'd3) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_init_idx <= r_init_idx + 2'd1;
                            r_state    <= ST_INIT;
                        end
                    end
                end
                ST_IDLE: begin
                    if (w_kick) begin
                        r_line  <= 1'b0;
                        r_col   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_LADDR;
`ifdef LCD_AUTO_REFRESH_EN
                        r_armed <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_armed) begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                ST_LADDR: r_state <= ST_LADDR_WT;
                ST_LADDR_WT: begin
                    // Address is presented during FETCH so the ROM word is
                    // ready in LATCH.
                    if (w_ready) begin
                        r_rom_addr <= {r_line, r_col};
                        r_state    <= ST_FETCH;
                    end
                end
                ST_FETCH: r_state <= ST_LATCH;
                ST_LATCH: r_state <= ST_CHAR_WT;
                ST_CHAR_WT: begin
                    if (w_ready) begin
                        if (r_col == 4'(LCD_COLS - 1)) begin
                            r_col <= 4'd0;
                            if (r_line) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
`ifdef LCD_AUTO_REFRESH_EN
                                r_armed <= 1'b1;
                                r_cnt   <= '0;
`endif
                            end else begin
                                r_line  <= 1'b1;
                                r_state <= ST_LADDR;
                            end
                        end else begin
                            r_col      <= r_col + 4'd1;
                            r_rom_addr <= {r_line, r_col + 4'd1};
                            r_state    <= ST_FETCH;
                        end
                    end
                end
                default: r_state <= ST_PWRUP;
            endcase
        end
    end

    lcd_byte_strobe #(
        .E_PULSE    (E_PULSE),
        .CMD_WAIT   (CMD_WAIT),
        .CLEAR_WAIT (CLEAR_WAIT)
    ) u_strobe (
        .clock       (clock),
        .reset       (reset),
        .i_go        (w_go),
        .i_rs        (w_rs),
        .i_byte      (w_byte),
        .i_long_wait (w_long),
        .o_lcd_rs    (lcdRs),
        .o_lcd_e     (lcdE),
        .o_lcd_data  (lcdData),
        .o_ready     (w_ready)
    );

    assign romAddr = r_rom_addr;
    assign lcdRw   = 1'b0;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_lcd_phrase_writer.sv
// Bench for lcd_phrase_writer: scoreboard of expected LCD bytes checked at each lcdE rise.
// Latency: n/a.
// Backpressure: n/a.
module tb_lcd_phrase_writer;

    localparam int POWERUP_WAIT = 10;
    localparam int E_PULSE      = 2;
    localparam int CMD_WAIT     = 4;
    localparam int CLEAR_WAIT   = 8;
    localparam int REFRESH_GAP  = 20;
    localparam int CHAR_CYC     = 3 + E_PULSE + CMD_WAIT;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] romAddr;
    logic [7:0] romData = 8'h00;
    logic       lcdRs, lcdRw, lcdE, busy, done;
    logic [7:0] lcdData;

    lcd_phrase_writer #(
        .POWERUP_WAIT (POWERUP_WAIT),
        .E_PULSE      (E_PULSE),
        .CMD_WAIT     (CMD_WAIT),
        .CLEAR_WAIT   (CLEAR_WAIT),
        .REFRESH_GAP  (REFRESH_GAP)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .romAddr (romAddr),
        .romData (romData),
        .lcdRs   (lcdRs),
        .lcdRw   (lcdRw),
        .lcdE    (lcdE),
        .lcdData (lcdData),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    // Phrase ROM model: registered read, one cycle late
    logic [7:0] rom [32];
    always @(posedge clock) romData <= rom[romAddr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input bit ok, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard: {rs, data} per expected E pulse
    logic [8:0] exp_q [$];
    bit         exp_done = 0;

    int   tot_pulses = 0, pass_pulses = 0, done_cnt = 0;
    int   first_rise_cyc = -1, last_rise_cyc = 0, last_fall_cyc = 0, done_cyc = 0;
    int   high_cnt = 0;
    bit   prev_e = 0, prev_rs = 0, prev_done = 0, prev_rise_rs = 0;
    logic [7:0] prev_dat = 8'h00;
    logic [8:0] e_ent;

    // Monitor: samples on the falling edge, away from the active edge
    always @(negedge clock) begin
        if (reset) begin
            high_cnt     = 0;
            prev_rise_rs = 0;
        end else begin
            if (lcdE && !prev_e) begin
                chk("setup_stable", {lcdRs, lcdData} == {prev_rs, prev_dat},
                    {lcdRs, lcdData}, {prev_rs, prev_dat});
                tot_pulses++;
                pass_pulses++;
                if (first_rise_cyc < 0) first_rise_cyc = cyc;
                chk("pulse_expected", exp_q.size() != 0, {lcdRs, lcdData}, 0);
                if (exp_q.size() != 0) begin
                    e_ent = exp_q.pop_front();
                    chk("pulse_byte", {lcdRs, lcdData} == e_ent, {lcdRs, lcdData}, e_ent);
                end
                if (lcdRs && prev_rise_rs)
                    chk("char_period", (cyc - last_rise_cyc) == CHAR_CYC, cyc - last_rise_cyc, CHAR_CYC);
                prev_rise_rs  = lcdRs;
                last_rise_cyc = cyc;
                high_cnt      = 1;
            end else if (lcdE) begin
                high_cnt++;
                chk("hold_e_high", {lcdRs, lcdData} == {prev_rs, prev_dat},
                    {lcdRs, lcdData}, {prev_rs, prev_dat});
            end else if (prev_e) begin
                chk("e_width", high_cnt == E_PULSE, high_cnt, E_PULSE);
                chk("hold_e_fall", {lcdRs, lcdData} == {prev_rs, prev_dat},
                    {lcdRs, lcdData}, {prev_rs, prev_dat});
                last_fall_cyc = cyc;
            end
            if (done) begin
                chk("done_one_cycle", prev_done == 1'b0, prev_done, 0);
                if (!prev_done) begin
                    chk("done_expected", exp_done == 1'b1, exp_done, 1);
                    chk("done_all_bytes", exp_q.size() == 0, exp_q.size(), 0);
                    chk("done_timing", (cyc - last_fall_cyc) == CMD_WAIT, cyc - last_fall_cyc, CMD_WAIT);
                    exp_done = 0;
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
        prev_e    = lcdE;
        prev_rs   = lcdRs;
        prev_dat  = lcdData;
        prev_done = done;
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_romAddr"}, romAddr == 5'd0, romAddr, 0);
        chk({tag, "_lcdRs"}, lcdRs == 1'b0, lcdRs, 0);
        chk({tag, "_lcdRw"}, lcdRw == 1'b0, lcdRw, 0);
        chk({tag, "_lcdE"}, lcdE == 1'b0, lcdE, 0);
        chk({tag, "_lcdData"}, lcdData == 8'h00, lcdData, 0);
        chk({tag, "_busy"}, busy == 1'b1, busy, 1);
        chk({tag, "_done"}, done == 1'b0, done, 0);
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    // Reference for one pass: line-0 address, 16 chars, line-1 address, 16 chars
    task automatic push_pass();
        exp_q.push_back({1'b0, 8'h80});
        for (int a = 0; a < 16; a++) exp_q.push_back({1'b1, rom[a]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int a = 16; a < 32; a++) exp_q.push_back({1'b1, rom[a]});
    endtask

    task automatic release_and_init(input int rel_dummy);
        int rel_cyc;
        push_init();
        first_rise_cyc = -1;
        @(negedge clock);
        reset   = 1'b0;
        rel_cyc = cyc + rel_dummy;
        for (int i = 0; i < 400 && busy; i++) @(negedge clock);
        chk("init_busy_fall", busy == 1'b0, busy, 0);
        chk("powerup_quiet", (first_rise_cyc - rel_cyc) > POWERUP_WAIT, first_rise_cyc - rel_cyc, POWERUP_WAIT + 1);
        chk("clear_wait", (cyc - last_fall_cyc) == CLEAR_WAIT, cyc - last_fall_cyc, CLEAR_WAIT);
        chk("init_bytes_done", exp_q.size() == 0, exp_q.size(), 0);
    endtask

    task automatic do_pass(input bit inject);
        int d0;
        push_pass();
        exp_done    = 1;
        pass_pulses = 0;
        d0          = done_cnt;
        repeat ($urandom_range(1, 6)) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("busy_after_start", busy == 1'b1, busy, 1);
        if (inject) begin
            for (int i = 0; i < 2000 && pass_pulses < 5; i++) @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        for (int i = 0; i < 4000 && done_cnt == d0; i++) @(negedge clock);
        chk("pass_done", done_cnt == d0 + 1, done_cnt - d0, 1);
        chk("pass_busy_low", busy == 1'b0, busy, 0);
        chk("pass_romAddr", romAddr == 5'd31, romAddr, 31);
        chk("pass_pulses", pass_pulses == 34, pass_pulses, 34);
    endtask

    task automatic randomize_rom();
        for (int a = 0; a < 32; a++) rom[a] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int d0, p0, tgt;
        for (int a = 0; a < 32; a++) rom[a] = 8'(a + 8'h41);

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        release_and_init(0);

        // Pass with the ASCII ROM image
        do_pass(1'b0);

`ifdef LCD_AUTO_REFRESH_EN
        push_pass();
        exp_done    = 1;
        pass_pulses = 0;
        d0          = done_cnt;
        for (int i = 0; i < 200 && !busy; i++) @(negedge clock);
        chk("auto_refresh_gap", (cyc - done_cyc) == REFRESH_GAP, cyc - done_cyc, REFRESH_GAP);
        for (int i = 0; i < 4000 && done_cnt == d0; i++) @(negedge clock);
        chk("auto_pass_pulses", pass_pulses == 34, pass_pulses, 34);
`else
        repeat (30) @(negedge clock);
        chk("idle_no_repass", pass_pulses == 34, pass_pulses, 34);

        // Randomised ROM contents; start during pulse 5 must be dropped
        for (int p = 0; p < 4; p++) begin
            randomize_rom();
            d0 = done_cnt;
            do_pass(p[0] == 1'b0);
            repeat (30) @(negedge clock);
            chk("start_not_queued", pass_pulses == 34, pass_pulses, 34);
            chk("single_done", done_cnt == d0 + 1, done_cnt - d0, 1);
        end

        // Reset in the middle of line 2
        randomize_rom();
        push_pass();
        exp_done    = 1;
        pass_pulses = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        tgt = 19 + $urandom_range(0, 12);
        for (int i = 0; i < 3000 && pass_pulses < tgt; i++) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        #1 check_reset_outputs("midreset");
        exp_q.delete();
        exp_done = 0;
        repeat (3) @(negedge clock);
        release_and_init(0);
        p0 = tot_pulses;
        repeat (60) @(negedge clock);
        chk("no_pulse_without_start", tot_pulses == p0, tot_pulses - p0, 0);
        chk("romAddr_after_reinit", romAddr == 5'd0, romAddr, 0);

        randomize_rom();
        do_pass(1'b0);
`endif

        repeat (5) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
